// File: rtl/a51_sequencer_if.sv
// rtl/a51_sequencer_if.sv - Host/datapath bundle for the A5/1 control sequencer
//
// Purpose: groups the run-control, key/frame, LFSR-control and keystream
//          handshake signals of a51_sequencer.
// Signals (named from the sequencer's point of view):
//   i_start, i_abort          run request / abort
//   i_key, i_frame            session key and frame number
//   o_lfsr_clr, o_step_en,
//   o_maj_en, o_load_en,
//   o_load_bit                LFSR datapath controls
//   i_ks_in                   keystream bit from the datapath
//   o_ks_out, o_ks_valid,
//   i_ks_ready                keystream valid/ready stream
//   o_busy, o_done,
//   o_stage, o_bit_cnt        status
// Modports: slave = sequencer, master = host/datapath side.
interface a51_sequencer_if #(
    parameter int KEY_W   = 64,
    parameter int FRAME_W = 22,
    parameter int CNT_W   = 9
);
    logic               i_start;
    logic               i_abort;
    logic [KEY_W-1:0]   i_key;
    logic [FRAME_W-1:0] i_frame;
    logic               o_lfsr_clr;
    logic               o_step_en;
    logic               o_maj_en;
    logic               o_load_en;
    logic               o_load_bit;
    logic               i_ks_in;
    logic               o_ks_out;
    logic               o_ks_valid;
    logic               i_ks_ready;
    logic               o_busy;
    logic               o_done;
    logic [2:0]         o_stage;
    logic [CNT_W-1:0]   o_bit_cnt;

    modport slave (
        input  i_start, i_abort, i_key, i_frame, i_ks_in, i_ks_ready,
        output o_lfsr_clr, o_step_en, o_maj_en, o_load_en, o_load_bit,
               o_ks_out, o_ks_valid, o_busy, o_done, o_stage, o_bit_cnt
    );

    modport master (
        output i_start, i_abort, i_key, i_frame, i_ks_in, i_ks_ready,
        input  o_lfsr_clr, o_step_en, o_maj_en, o_load_en, o_load_bit,
               o_ks_out, o_ks_valid, o_busy, o_done, o_stage, o_bit_cnt
    );
endinterface

// File: rtl/a51_sequencer.sv
// rtl/a51_sequencer.sv - Phase sequencer for the A5/1 R1/R2/R3 LFSR datapath
//
// Purpose: on START captures key and frame, then walks the LFSR datapath
//          through CLEAR, KEYLOAD, FRAMELOAD, MIX and OUTPUT, delivering the
//          keystream bit-serially over a valid/ready handshake.
// Ports:
//   i_c    clock, rising edge
//   i_clr  asynchronous active-high reset
//   s_if   a51_sequencer_if.slave (control, datapath and stream signals)
module a51_sequencer #(
    parameter int KEY_W      = 64,
    parameter int FRAME_W    = 22,
    parameter int MIX_CYCLES = 100,
    parameter int KS_BITS    = 228,
    parameter int CNT_W      = 9
) (
    input  logic              i_c,
    input  logic              i_clr,
    a51_sequencer_if.slave    s_if
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_KEYLOAD   = 3'd2,
        S_FRAMELOAD = 3'd3,
        S_MIX       = 3'd4,
        S_OUTPUT    = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_W - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES - 1);
    localparam logic [CNT_W-1:0] KS_LAST    = CNT_W'(KS_BITS - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [KEY_W-1:0]   r_key;
    logic [FRAME_W-1:0] r_frame;

    logic [KEY_W-1:0]   w_key_sh;
    logic [FRAME_W-1:0] w_frame_sh;
    logic               w_beat;

    // Shifting rather than indexing keeps the counter width independent of
    // the key/frame widths; bit 0 of the shifted value is the current bit.
    assign w_key_sh   = r_key >> r_cnt;
    assign w_frame_sh = r_frame >> r_cnt;
    assign w_beat     = (r_state == S_OUTPUT) && s_if.i_ks_ready;

    always_ff @(posedge i_c or posedge i_clr) begin
        if (i_clr) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_key   <= '0;
            r_frame <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // ABORT is meaningless here, so START always wins.
                    if (s_if.i_start) begin
                        r_key   <= s_if.i_key;
                        r_frame <= s_if.i_frame;
                        r_cnt   <= '0;
                        r_state <= S_CLEAR;
                    end
                end
                default: begin
                    if (s_if.i_abort) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        case (r_state)
                            S_CLEAR: begin
                                r_cnt   <= '0;
                                r_state <= S_KEYLOAD;
                            end
                            S_KEYLOAD: begin
                                if (r_cnt == KEY_LAST) begin
                                    r_cnt   <= '0;
                                    r_state <= S_FRAMELOAD;
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end
                            S_FRAMELOAD: begin
                                if (r_cnt == FRAME_LAST) begin
                                    r_cnt   <= '0;
                                    r_state <= S_MIX;
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end
                            S_MIX: begin
                                if (r_cnt == MIX_LAST) begin
                                    r_cnt   <= '0;
                                    r_state <= S_OUTPUT;
                                end else begin
                                    r_cnt <= r_cnt + 1'b1;
                                end
                            end
                            S_OUTPUT: begin
                                // Without a beat everything holds, matching the
                                // frozen LFSRs.
                                if (w_beat) begin
                                    if (r_cnt == KS_LAST) begin
                                        r_cnt   <= '0;
                                        r_state <= S_DONE;
                                    end else begin
                                        r_cnt <= r_cnt + 1'b1;
                                    end
                                end
                            end
                            default: begin
                                r_cnt   <= '0;
                                r_state <= S_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // Moore decode straight from the registered state: no added latency.
    always_comb begin
        s_if.o_lfsr_clr = 1'b0;
        s_if.o_step_en  = 1'b0;
        s_if.o_maj_en   = 1'b0;
        s_if.o_load_en  = 1'b0;
        s_if.o_load_bit = 1'b0;
        s_if.o_ks_out   = 1'b0;
        s_if.o_ks_valid = 1'b0;
        s_if.o_busy     = 1'b0;
        s_if.o_done     = 1'b0;
        case (r_state)
            S_CLEAR: begin
                s_if.o_lfsr_clr = 1'b1;
                s_if.o_busy     = 1'b1;
            end
            S_KEYLOAD: begin
                s_if.o_step_en  = 1'b1;
                s_if.o_load_en  = 1'b1;
                s_if.o_load_bit = w_key_sh[0];
                s_if.o_busy     = 1'b1;
            end
            S_FRAMELOAD: begin
                s_if.o_step_en  = 1'b1;
                s_if.o_load_en  = 1'b1;
                s_if.o_load_bit = w_frame_sh[0];
                s_if.o_busy     = 1'b1;
            end
            S_MIX: begin
                s_if.o_step_en = 1'b1;
                s_if.o_maj_en  = 1'b1;
                s_if.o_busy    = 1'b1;
            end
            S_OUTPUT: begin
                s_if.o_step_en  = s_if.i_ks_ready;
                s_if.o_maj_en   = 1'b1;
                s_if.o_ks_valid = 1'b1;
                s_if.o_ks_out   = s_if.i_ks_in;
                s_if.o_busy     = 1'b1;
            end
            S_DONE: begin
                s_if.o_done = 1'b1;
            end
            default: begin
                s_if.o_done = 1'b0;
            end
        endcase
    end

    assign s_if.o_stage   = r_state;
    assign s_if.o_bit_cnt = r_cnt;
endmodule

// File: doc/a51_sequencer.md
Name: a51_sequencer

Overview:
- Control sequencer for the A5/1 LFSR datapath (R1/R2/R3 plus majority-clock logic).
- On START, captures a 64-bit session key and a 22-bit frame number, then walks the datapath through five phases: clear, key load, frame load, 100-cycle mix, and keystream output.
- Delivers keystream bit-serially over a valid/ready handshake; backpressure freezes the LFSRs.
- Replaces free-running stage decoding with explicit phase control, stall and abort.

Parameters:
- KEY_W, 64, key length in bits.
- FRAME_W, 22, frame-number length in bits.
- MIX_CYCLES, 100, majority-clocked discard cycles.
- KS_BITS, 228, keystream bits delivered per run.
- CNT_W, 9, phase bit-counter width; must hold max(KEY_W, FRAME_W, MIX_CYCLES, KS_BITS) - 1.

Ports:
- C  in  1  clock, rising edge.
- CLR  in  1  asynchronous active-high reset.
- START  in  1  run request, sampled only in IDLE or DONE.
- ABORT  in  1  synchronous abort of a run in progress.
- KEY  in  KEY_W  session key, captured when START is accepted.
- FRAME  in  FRAME_W  frame number, captured when START is accepted.
- LFSR_CLR  out  1  synchronous clear to all three LFSRs.
- STEP_EN  out  1  LFSR clock enable.
- MAJ_EN  out  1  clocking mode: 1 = majority clocking, 0 = all registers clock.
- LOAD_EN  out  1  XOR LOAD_BIT into the feedback of all three registers.
- LOAD_BIT  out  1  current key or frame bit.
- KS_IN  in  1  keystream bit from the datapath (combinational from current LFSR state).
- KS_OUT  out  1  keystream bit to the consumer.
- KS_VALID  out  1  KS_OUT is valid.
- KS_READY  in  1  consumer accepts the bit.
- BUSY  out  1  run in progress (states CLEAR through OUTPUT).
- DONE  out  1  run complete, held.
- STAGE  out  3  current state encoding.
- BIT_CNT  out  CNT_W  index within the current phase.

Behaviour:
- CLR is asynchronous: state = IDLE, counter = 0, captured key and frame = 0. All outputs read 0 while CLR is high and after reset.
- Outputs are Moore-decoded combinationally from the registered state and counter; there is no extra output latency.
- STAGE encoding: IDLE=0, CLEAR=1, KEYLOAD=2, FRAMELOAD=3, MIX=4, OUTPUT=5, DONE=6.
- IDLE/DONE:
  - START=1 captures KEY and FRAME, clears the counter, and moves to CLEAR.
  - DONE=1 only while in DONE.
  - START is ignored in every other state.
- CLEAR: one cycle; LFSR_CLR=1, all other controls 0; then KEYLOAD.
- KEYLOAD: KEY_W cycles.
  - STEP_EN=1, LOAD_EN=1, MAJ_EN=0.
  - LOAD_BIT = key[BIT_CNT], LSB first.
  - At BIT_CNT=KEY_W-1: counter to 0, next state FRAMELOAD.
- FRAMELOAD: FRAME_W cycles; same controls, LOAD_BIT = frame[BIT_CNT], LSB first; then MIX.
- MIX: MIX_CYCLES cycles; STEP_EN=1, MAJ_EN=1, LOAD_EN=0; then OUTPUT.
- OUTPUT:
  - KS_VALID=1, KS_OUT=KS_IN, MAJ_EN=1, STEP_EN=KS_READY.
  - The counter advances only on a handshake beat (KS_VALID & KS_READY).
  - With KS_READY low, all state holds and the LFSRs are frozen.
  - Beat at BIT_CNT=KS_BITS-1 moves to DONE.
- Outside OUTPUT: KS_VALID=0 and KS_OUT=0.
- Outside KEYLOAD/FRAMELOAD: LOAD_BIT=0.
- ABORT in CLEAR..OUTPUT: next state IDLE, counter 0; DONE is not asserted.
  - Priority: CLR > ABORT > phase progression.
  - ABORT in IDLE/DONE is ignored; START is still honoured.
- START and ABORT together in IDLE/DONE: START wins.
- Counter never wraps: each phase ends exactly at its terminal count.
- KEY/FRAME changes after capture have no effect on the run.
- Timing: START accepted at edge E0 with KS_READY held at 1 gives DONE=1 after edge E0+415 (1+64+22+100+228).

Test Plan:
- Reset mid-run: assert CLR during MIX at BIT_CNT=40 -> STAGE=0, all outputs 0 immediately; a new START runs the full 415-cycle sequence.
- Full run, KS_READY=1, KEY=64'h0123_4567_89AB_CDEF, FRAME=22'h2F_00D -> LOAD_BIT sequence is 1,1,1,1,0,1,1,1,... LSB-first for 64 cycles then frame bits; exactly 228 KS_VALID beats; DONE rises 415 cycles after START.
- Backpressure: drop KS_READY for 5 cycles at beat 10 -> STEP_EN=0 and BIT_CNT=10 held; DONE delayed to cycle 420; beat count still 228.
- START pulsed during KEYLOAD with a different KEY -> ignored; LOAD_BIT stream matches the original key.
- ABORT during FRAMELOAD at BIT_CNT=7 -> next cycle STAGE=0, BUSY=0, DONE=0, STEP_EN=0.
- START in DONE together with ABORT -> restart into CLEAR, DONE drops the next cycle.
